// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: parses SYNC/ADDR/LEN/payload/CHK frames from the UART byte stream
// and replays checksum-verified payloads as single-byte register writes.
module uart_frame_ctrl #(
    parameter int         CLK_FRE      = 50,
    parameter int         BAUD_RATE    = 115200,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    output logic       rx_data_ready,
    output logic       reg_wr_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wr_data,
    input  logic       reg_wr_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       err_valid,
    output logic [1:0] err_code
);
    localparam int TIMEOUT_CYC = CLK_FRE * 1000000 / BAUD_RATE * TIMEOUT_BITS;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {IDLE, ADDR, LEN, PAYLOAD, CHK, WRITE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      base_q, base_d, len_q, len_d, idx_q, idx_d, sum_q, sum_d;
    logic [7:0]      addr_q, addr_d, data_q, data_d, nxt;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [1:0]      code_q, code_d;
    logic            rdy_q, wr_en_q, wr_en_d, done_q, done_d, err_q, err_d;
    logic            acc, last, pay_we;
    logic [7:0]      pay_q [2**IW];

    assign acc  = rx_data_valid && rdy_q;
    assign last = idx_q == len_q - 8'd1;
    assign nxt  = idx_q + 8'd1;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        tmo_d   = tmo_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_en_d = wr_en_q;
        code_d  = code_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pay_we  = 1'b0;
        // inter-byte timer runs only while a frame header/payload is being received
        if (state_q inside {ADDR, LEN, PAYLOAD, CHK}) begin
            tmo_d = acc ? '0 : tmo_q + TW'(1);
            if (!acc && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d = IDLE;
                err_d   = 1'b1;
                code_d  = 2'd3;
            end
        end
        case (state_q)
            IDLE: if (acc && rx_data == SYNC_BYTE) begin
                state_d = ADDR;
                tmo_d   = '0;
            end
            ADDR: if (acc) begin
                base_d  = rx_data;
                sum_d   = rx_data;
                state_d = LEN;
            end
            LEN: if (acc) begin
                if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    code_d  = 2'd1;
                end else begin
                    len_d   = rx_data;
                    sum_d   = sum_q + rx_data;
                    idx_d   = 8'd0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (acc) begin
                pay_we  = 1'b1;
                sum_d   = sum_q + rx_data;
                idx_d   = nxt;
                state_d = last ? CHK : PAYLOAD;
            end
            CHK: if (acc) begin
                if (rx_data == sum_q) begin
                    idx_d   = 8'd0;
                    wr_en_d = 1'b1;
                    addr_d  = base_q;
                    data_d  = pay_q[0];
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                end
            end
            WRITE: if (reg_wr_ready) begin
                if (last) begin
                    wr_en_d = 1'b0;
                    done_d  = 1'b1;
                    idx_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    idx_d  = nxt;
                    addr_d = base_q + nxt;
                    data_d = pay_q[nxt[IW-1:0]];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            tmo_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            code_q  <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            code_q  <= code_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdy_q   <= state_d != WRITE;
        end
    end

    always_ff @(posedge clk) begin
        if (pay_we) pay_q[idx_q[IW-1:0]] <= rx_data;
    end

    assign rx_data_ready = rdy_q;
    assign reg_wr_en     = wr_en_q;
    assign reg_addr      = addr_q;
    assign reg_wr_data   = data_q;
    assign busy          = state_q != IDLE;
    assign frame_done    = done_q;
    assign err_valid     = err_q;
    assign err_code      = code_q;
endmodule
